snake_body_ctrl: RTL and testbench

SNAKE_BODY_CTRL -- requirements
Module: snake_body_ctrl

---
 rtl/snake_pkg.sv | 32 +++
 rtl/snake_next_head.sv | 45 ++++
 rtl/snake_body_ctrl.sv | 131 +++++++++++++
 tb/tb_snake_body_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snake_pkg.sv
// Shared types and constants for the snake body controller.
// Build option: WALL_WRAP_EN (see snake_next_head) selects wrap-around walls.
package snake_pkg;

   localparam int MAX_LEN = 50;

   typedef logic [7:0] coord_t;  // {x[3:0], y[3:0]}

   typedef enum logic [1:0] {
      DIR_UP    = 2'd0,
      DIR_DOWN  = 2'd1,
      DIR_LEFT  = 2'd2,
      DIR_RIGHT = 2'd3
   } dir_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DEAD = 2'd2
   } state_t;

   localparam coord_t     RST_HEAD = 8'h48;
   localparam coord_t     RST_NECK = 8'h38;
   localparam coord_t     RST_TAIL = 8'h28;
   localparam logic [5:0] RST_LEN  = 6'd3;

   // Opposite directions share the axis bit and differ in the sense bit.
   function automatic logic is_opposite(input dir_t a, input dir_t b);
      return (a[1] == b[1]) && (a[0] != b[0]);
   endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head cell and wall detection.
// Build option: WALL_WRAP_EN defined -> head wraps modulo 16, walls never fatal;
// undefined -> stepping off the 16x16 grid is flagged through off_grid.
module snake_next_head
   import snake_pkg::*;
(
   input  coord_t head,
   input  dir_t   dir,
   output coord_t next_head,
   output logic   off_grid
);

   logic [3:0] hx, hy, nx, ny;

   assign hx        = head[7:4];
   assign hy        = head[3:0];
   assign next_head = {nx, ny};

   // Step one cell in the current direction with plain 4-bit arithmetic.
   always_comb begin
      nx = hx;
      ny = hy;
      case (dir)
         DIR_UP:    ny = hy - 4'd1;
         DIR_DOWN:  ny = hy + 4'd1;
         DIR_LEFT:  nx = hx - 4'd1;
         default:   nx = hx + 4'd1;
      endcase
   end

   // Flag a move that would leave the grid.
   always_comb begin
`ifdef WALL_WRAP_EN
      off_grid = 1'b0;
`else
      case (dir)
         DIR_UP:    off_grid = (hy == 4'd0);
         DIR_DOWN:  off_grid = (hy == 4'd15);
         DIR_LEFT:  off_grid = (hx == 4'd0);
         default:   off_grid = (hx == 4'd15);
      endcase
`endif
   end

endmodule

// File: rtl/snake_body_ctrl.sv
// Snake body controller: direction latch, body shift register, growth,
// collision detection and game FSM (IDLE/RUN/DEAD).
// Build option: WALL_WRAP_EN selects wrap-around walls instead of fatal walls.
// Invariant: body slots at index >= length always hold a copy of the tail.
module snake_body_ctrl
   import snake_pkg::*;
#(
   parameter int MAX_LEN = snake_pkg::MAX_LEN
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic                 tick,
   input  logic [1:0]           dir_req,
   input  logic [7:0]           apple_cord,
   input  logic [3:0]           x,
   input  logic [3:0]           y,
   output coord_t [MAX_LEN-1:0] body,
   output logic [5:0]           length,
   output logic                 goodColl,
   output logic                 badColl,
   output logic                 body_px,
   output logic [1:0]           state
);

   state_t               state_q, state_d;
   dir_t                 dir_q, dir_in;
   logic [5:0]           len_q, len_new, tail_idx;
   coord_t [MAX_LEN-1:0] body_q;
   coord_t               next_head, tail_new;
   logic                 off_grid, hit_self, px_hit;
   logic                 eat, move, fatal, restart;
   logic                 good_q, bad_q, px_q;

   assign dir_in = dir_t'(dir_req);

   snake_next_head u_next_head (
      .head      (body_q[0]),
      .dir       (dir_q),
      .next_head (next_head),
      .off_grid  (off_grid)
   );

   // Scan live segments: self-hit excludes head and tail, pixel match covers all.
   always_comb begin
      hit_self = 1'b0;
      px_hit   = 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
         if ((i >= 1) && (i < int'(len_q) - 1) && (body_q[i] == next_head))
            hit_self = 1'b1;
         if ((i < int'(len_q)) && (body_q[i] == {x, y}))
            px_hit = 1'b1;
      end
   end

   assign move     = (state_q == ST_RUN) && tick;
   assign fatal    = move && (off_grid || hit_self);
   assign eat      = (next_head == apple_cord);
   assign restart  = (state_q == ST_DEAD) && start;
   assign len_new  = (eat && (int'(len_q) < MAX_LEN)) ? len_q + 6'd1 : len_q;
   // New tail sits one slot before the new length, i.e. old slot len_new-2.
   assign tail_idx = len_new - 6'd2;
   assign tail_new = body_q[tail_idx];

   // Game FSM state register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // Game FSM next state; start is ignored while running.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start) state_d = ST_RUN;
         ST_RUN:  if (fatal) state_d = ST_DEAD;
         ST_DEAD: if (start) state_d = ST_IDLE;
         default: state_d = ST_IDLE;
      endcase
   end

   // Body, length, direction and collision pulses.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 2; i < MAX_LEN; i++) body_q[i] <= RST_TAIL;
         body_q[0] <= RST_HEAD;
         body_q[1] <= RST_NECK;
         len_q     <= RST_LEN;
         dir_q     <= DIR_RIGHT;
         good_q    <= 1'b0;
         bad_q     <= 1'b0;
      end else begin
         good_q <= 1'b0;
         bad_q  <= 1'b0;
         if (restart) begin
            for (int i = 2; i < MAX_LEN; i++) body_q[i] <= RST_TAIL;
            body_q[0] <= RST_HEAD;
            body_q[1] <= RST_NECK;
            len_q     <= RST_LEN;
            dir_q     <= DIR_RIGHT;
         end else begin
            if (!is_opposite(dir_in, dir_q)) dir_q <= dir_in;
            if (move) begin
               if (fatal) begin
                  bad_q <= 1'b1;
               end else begin
                  body_q[0] <= next_head;
                  for (int i = 1; i < MAX_LEN; i++)
                     body_q[i] <= (i < int'(len_new)) ? body_q[i-1] : tail_new;
                  len_q  <= len_new;
                  good_q <= eat;
               end
            end
         end
      end
   end

   // Registered pixel query, one cycle behind x/y.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) px_q <= 1'b0;
      else        px_q <= px_hit;
   end

   assign body     = body_q;
   assign length   = len_q;
   assign goodColl = good_q;
   assign badColl  = bad_q;
   assign body_px  = px_q;
   assign state    = state_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// Self-checking bench for snake_body_ctrl: a queue-based model of the live
// segments predicts each snapshot (flags, state, length, full body array).
module tb_snake_body_ctrl;

   localparam int ML = 50;
   localparam int BW = ML * 8;
   localparam int SW = BW + 10;

   logic                 clk = 1'b0;
   logic                 reset = 1'b0;
   logic                 start = 1'b0;
   logic                 tick = 1'b0;
   logic [1:0]           dir_req = 2'd3;
   logic [7:0]           apple_cord = 8'hEE;
   logic [3:0]           x = 4'd0;
   logic [3:0]           y = 4'd0;
   logic [ML-1:0][7:0]   body;
   logic [5:0]           length;
   logic                 goodColl, badColl, body_px;
   logic [1:0]           state;

   snake_body_ctrl #(.MAX_LEN(ML)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .tick       (tick),
      .dir_req    (dir_req),
      .apple_cord (apple_cord),
      .x          (x),
      .y          (y),
      .body       (body),
      .length     (length),
      .goodColl   (goodColl),
      .badColl    (badColl),
      .body_px    (body_px),
      .state      (state)
   );

   // clock
   always #5 clk = ~clk;

   // scoreboard and model state
   logic [SW-1:0] exp_q[$];
   logic [7:0]    seg[$];
   logic [1:0]    m_dir;
   logic [1:0]    m_state;
   logic          m_good, m_bad;
   int            n_checks = 0;
   int            n_fail = 0;

   task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_init();
      seg = {8'h48, 8'h38, 8'h28};
      m_dir = 2'd3;
      m_state = 2'd0;
      m_good = 1'b0;
      m_bad = 1'b0;
   endtask

   // returns {off_grid, next cell}
   function automatic logic [8:0] model_next(input logic [7:0] h, input logic [1:0] d);
      logic [3:0] hx, hy, nx, ny;
      logic off;
      hx = h[7:4];
      hy = h[3:0];
      nx = hx;
      ny = hy;
      off = 1'b0;
      case (d)
         2'd0: begin ny = hy - 4'd1; off = (hy == 4'd0);  end
         2'd1: begin ny = hy + 4'd1; off = (hy == 4'd15); end
         2'd2: begin nx = hx - 4'd1; off = (hx == 4'd0);  end
         default: begin nx = hx + 4'd1; off = (hx == 4'd15); end
      endcase
`ifdef WALL_WRAP_EN
      off = 1'b0;
`endif
      return {off, nx, ny};
   endfunction

   task automatic model_tick();
      logic [8:0] r;
      logic hit;
      m_good = 1'b0;
      m_bad = 1'b0;
      if (m_state == 2'd1) begin
         r = model_next(seg[0], m_dir);
         hit = 1'b0;
         for (int i = 1; i < seg.size() - 1; i++) if (seg[i] == r[7:0]) hit = 1'b1;
         if (r[8] || hit) begin
            m_bad = 1'b1;
            m_state = 2'd2;
         end else begin
            m_good = (r[7:0] == apple_cord);
            seg.push_front(r[7:0]);
            if (!m_good || seg.size() > ML) void'(seg.pop_back());
         end
      end
   endtask

   function automatic logic [SW-1:0] model_snap();
      logic [BW-1:0] b;
      for (int i = 0; i < ML; i++)
         b[i*8 +: 8] = (i < seg.size()) ? seg[i] : seg[seg.size()-1];
      return {m_good, m_bad, m_state, 6'(seg.size()), b};
   endfunction

   task automatic pop_exp(output logic [SW-1:0] e);
      check("queue_depth", BW'(exp_q.size()), BW'(1));
      e = '0;
      if (exp_q.size() > 0) e = exp_q.pop_front();
   endtask

   task automatic compare_snap();
      logic [SW-1:0] e;
      pop_exp(e);
      check("goodColl", BW'(goodColl), BW'(e[BW+9]));
      check("badColl",  BW'(badColl),  BW'(e[BW+8]));
      check("state",    BW'(state),    BW'(e[BW+7:BW+6]));
      check("length",   BW'(length),   BW'(e[BW+5:BW]));
      check("body",     body,          e[BW-1:0]);
   endtask

   // driver tasks
   task automatic do_reset();
      @(negedge clk);
      dir_req = 2'd3;
      reset = 1'b0;
      repeat (2) @(negedge clk);
      model_init();
      exp_q.push_back(model_snap());
      compare_snap();
      reset = 1'b1;
   endtask

   task automatic do_start(input logic with_tick);
      @(negedge clk);
      start = 1'b1;
      tick = with_tick;
      m_good = 1'b0;
      m_bad = 1'b0;
      if (m_state == 2'd0) m_state = 2'd1;
      else if (m_state == 2'd2) model_init();
      exp_q.push_back(model_snap());
      @(negedge clk);
      start = 1'b0;
      tick = 1'b0;
      compare_snap();
   endtask

   task automatic do_tick();
      @(negedge clk);
      tick = 1'b1;
      model_tick();
      exp_q.push_back(model_snap());
      @(negedge clk);
      tick = 1'b0;
      compare_snap();
   endtask

   task automatic set_dir(input logic [1:0] d);
      @(negedge clk);
      dir_req = d;
      @(negedge clk);
      if (!((d[1] == m_dir[1]) && (d[0] != m_dir[0]))) m_dir = d;
   endtask

   task automatic probe(input logic [7:0] c);
      logic [SW-1:0] e;
      logic member;
      @(negedge clk);
      {x, y} = c;
      member = 1'b0;
      foreach (seg[i]) if (seg[i] == c) member = 1'b1;
      exp_q.push_back(SW'(member));
      @(negedge clk);
      pop_exp(e);
      check("body_px", BW'(body_px), BW'(e[0]));
   endtask

   initial begin
      logic [8:0]  r;
      logic [1:0]  want;
      logic [SW-1:0] e;

      // reset state and pixel query at reset
      do_reset();
      probe(8'h48);
      probe(8'h28);
      probe(8'h58);

      // basic move right
      do_start(1'b0);
      do_tick();

      // eat apple, single-cycle pulse, reversal ignored
      do_reset();
      do_start(1'b0);
      apple_cord = 8'h58;
      do_tick();
      apple_cord = 8'hEE;
      set_dir(2'd2);
      check("good_once", BW'(goodColl), BW'(1'b0));
      do_tick();

      // move into the vacating tail cell is legal
      do_reset();
      do_start(1'b0);
      apple_cord = 8'h58;
      do_tick();
      apple_cord = 8'hEE;
      do_tick();
      set_dir(2'd1); do_tick();
      set_dir(2'd2); do_tick();
      set_dir(2'd0); do_tick();

      // length 5 turning into segment 3 is fatal; DEAD ignores tick
      do_reset();
      do_start(1'b0);
      apple_cord = 8'h58; do_tick();
      apple_cord = 8'h68; do_tick();
      apple_cord = 8'hEE;
      set_dir(2'd1); do_tick();
      set_dir(2'd2); do_tick();
      set_dir(2'd0); do_tick();
      do_tick();

      // restart from DEAD with coincident tick, then start again
      set_dir(2'd3);
      do_start(1'b1);
      do_start(1'b0);

      // walk to the right wall and across it
      for (int k = 0; k < 12; k++) do_tick();
      do_tick();

      // reset in the same cycle as a tick
      do_reset();
      do_start(1'b0);
      do_tick();
      @(negedge clk);
      tick = 1'b1;
      reset = 1'b0;
      model_init();
      exp_q.push_back(model_snap());
      @(negedge clk);
      tick = 1'b0;
      compare_snap();
      reset = 1'b1;

      // serpentine growth up to MAX_LEN, then eat while saturated
      do_start(1'b0);
      for (int k = 0; k < ML; k++) begin
         want = m_dir;
         if (m_dir == 2'd3 && seg[0][7:4] == 4'd14) want = 2'd1;
         else if (m_dir == 2'd2 && seg[0][7:4] == 4'd1) want = 2'd1;
         else if (m_dir == 2'd1) want = (seg[0][7:4] == 4'd14) ? 2'd2 : 2'd3;
         if (want != m_dir) set_dir(want);
         r = model_next(seg[0], m_dir);
         apple_cord = r[7:0];
         do_tick();
      end
      apple_cord = 8'hEE;
      do_tick();

      // pixel queries on the long snake
      probe(seg[0]);
      probe(seg[seg.size()-1]);
      probe(8'h00);
      for (int k = 0; k < 6; k++) probe(8'($urandom_range(0, 255)));

      if (exp_q.size() != 0) pop_exp(e);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
